// File: rtl/player_action_fsm.sv
// Per-player action controller on the 20 Hz game tick: movement controls for
// the physics engine, punch/kick attack sequencing, hit-stun and state export.
module player_action_fsm #(
    parameter int unsigned PUNCH_WINDUP  = 2,
    parameter int unsigned PUNCH_ACTIVE  = 2,
    parameter int unsigned PUNCH_RECOVER = 3,
    parameter int unsigned KICK_WINDUP   = 3,
    parameter int unsigned KICK_ACTIVE   = 3,
    parameter int unsigned KICK_RECOVER  = 4,
    parameter int unsigned HITSTUN       = 6,
    parameter int unsigned MIN_AIR       = 2
) (
    input  logic       CLK_20Hz,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_punch,
    input  logic       btn_kick,
    input  logic       on_floor,
    input  logic       got_hit,
    output logic       movingLeft,
    output logic       movingRight,
    output logic       isJumping,
    output logic       attack_active,
    output logic [1:0] attack_type,
    output logic [2:0] action_state
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned TYPE_W = 2;

    localparam logic [TYPE_W-1:0] TYPE_NONE  = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] TYPE_PUNCH = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] TYPE_KICK  = TYPE_W'(2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WALK    = 3'd1,
        S_AIR     = 3'd2,
        S_WINDUP  = 3'd3,
        S_ACTIVE  = 3'd4,
        S_RECOVER = 3'd5,
        S_HITSTUN = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  air_q, air_d;
    logic [TYPE_W-1:0] type_q, type_d;

    logic jump_prev_q, punch_prev_q, kick_prev_q;

    logic moving_left_q, moving_left_d;
    logic moving_right_q, moving_right_d;
    logic is_jumping_q, is_jumping_d;
    logic attack_active_q, attack_active_d;

    logic jump_press, punch_press, kick_press;
    logic move_one;
    logic phase_end;
    logic move_ok;

    // Rising-edge detection on the synchronized action buttons
    always_comb begin
        jump_press  = btn_jump  & ~jump_prev_q;
        punch_press = btn_punch & ~punch_prev_q;
        kick_press  = btn_kick  & ~kick_prev_q;
        move_one    = btn_left ^ btn_right;
        phase_end   = (cnt_q <= CNT_W'(1));
    end

    // Next-state, phase counters and registered-output precomputation
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        air_d           = air_q;
        type_d          = type_q;
        is_jumping_d    = 1'b0;
        move_ok         = 1'b0;
        moving_left_d   = 1'b0;
        moving_right_d  = 1'b0;
        attack_active_d = 1'b0;

        if (got_hit) begin
            state_d = S_HITSTUN;
            cnt_d   = CNT_W'(HITSTUN);
            type_d  = TYPE_NONE;
            air_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_WALK: begin
                    if (punch_press) begin
                        state_d = S_WINDUP;
                        type_d  = TYPE_PUNCH;
                        cnt_d   = CNT_W'(PUNCH_WINDUP);
                    end else if (kick_press) begin
                        state_d = S_WINDUP;
                        type_d  = TYPE_KICK;
                        cnt_d   = CNT_W'(KICK_WINDUP);
                    end else if (jump_press && on_floor) begin
                        state_d      = S_AIR;
                        air_d        = CNT_W'(MIN_AIR);
                        is_jumping_d = 1'b1;
                    end else if (move_one) begin
                        state_d = S_WALK;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_AIR: begin
                    // on_floor is ignored until the air counter drains
                    if (air_q != '0) begin
                        air_d = air_q - CNT_W'(1);
                    end else if (on_floor) begin
                        state_d = S_IDLE;
                    end
                end
                S_WINDUP: begin
                    if (phase_end) begin
                        state_d = S_ACTIVE;
                        cnt_d   = (type_q == TYPE_KICK) ? CNT_W'(KICK_ACTIVE)
                                                        : CNT_W'(PUNCH_ACTIVE);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_ACTIVE: begin
                    if (phase_end) begin
                        state_d = S_RECOVER;
                        cnt_d   = (type_q == TYPE_KICK) ? CNT_W'(KICK_RECOVER)
                                                        : CNT_W'(PUNCH_RECOVER);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_RECOVER: begin
                    if (phase_end) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        type_d  = TYPE_NONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_HITSTUN: begin
                    if (phase_end) begin
                        state_d = on_floor ? S_IDLE : S_AIR;
                        cnt_d   = '0;
                        air_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    air_d   = '0;
                    type_d  = TYPE_NONE;
                end
            endcase
        end

        move_ok         = (state_d == S_IDLE) || (state_d == S_WALK) || (state_d == S_AIR);
        moving_left_d   = move_ok & btn_left  & ~btn_right;
        moving_right_d  = move_ok & btn_right & ~btn_left;
        attack_active_d = (state_d == S_ACTIVE);
    end

    // State, counters, edge history and output registers
    always_ff @(posedge CLK_20Hz) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            air_q           <= '0;
            type_q          <= TYPE_NONE;
            jump_prev_q     <= 1'b1;
            punch_prev_q    <= 1'b1;
            kick_prev_q     <= 1'b1;
            moving_left_q   <= 1'b0;
            moving_right_q  <= 1'b0;
            is_jumping_q    <= 1'b0;
            attack_active_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            air_q           <= air_d;
            type_q          <= type_d;
            jump_prev_q     <= btn_jump;
            punch_prev_q    <= btn_punch;
            kick_prev_q     <= btn_kick;
            moving_left_q   <= moving_left_d;
            moving_right_q  <= moving_right_d;
            is_jumping_q    <= is_jumping_d;
            attack_active_q <= attack_active_d;
        end
    end

    assign movingLeft    = moving_left_q;
    assign movingRight   = moving_right_q;
    assign isJumping     = is_jumping_q;
    assign attack_active = attack_active_q;
    assign attack_type   = type_q;
    assign action_state  = state_q;

endmodule

// File: tb/tb_player_action_fsm.sv
// Scoreboard bench for player_action_fsm: directed ticks push hand-computed
// expected outputs; a monitor compares them one tick at a time.
`timescale 1ns/1ps
module tb_player_action_fsm;

    logic       CLK_20Hz = 1'b0;
    logic       reset;
    logic       btn_left, btn_right, btn_jump, btn_punch, btn_kick;
    logic       on_floor, got_hit;
    logic       movingLeft, movingRight, isJumping, attack_active;
    logic [1:0] attack_type;
    logic [2:0] action_state;

    logic [8:0] dut_vec;
    logic [8:0] exp_q[$];
    string      name_q[$];
    logic [8:0] exp_v;
    string      name_v;

    int checks   = 0;
    int failures = 0;

    player_action_fsm dut (
        .CLK_20Hz     (CLK_20Hz),
        .reset        (reset),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_jump     (btn_jump),
        .btn_punch    (btn_punch),
        .btn_kick     (btn_kick),
        .on_floor     (on_floor),
        .got_hit      (got_hit),
        .movingLeft   (movingLeft),
        .movingRight  (movingRight),
        .isJumping    (isJumping),
        .attack_active(attack_active),
        .attack_type  (attack_type),
        .action_state (action_state)
    );

    always #5 CLK_20Hz = ~CLK_20Hz;

    assign dut_vec = {movingLeft, movingRight, isJumping, attack_active, attack_type, action_state};

    // {movingLeft, movingRight, isJumping, attack_active, attack_type, action_state}
    function automatic logic [8:0] E(input logic ml, input logic mr, input logic j,
                                     input logic aa, input logic [1:0] at,
                                     input logic [2:0] st);
        return {ml, mr, j, aa, at, st};
    endfunction

    // Queue the expectation for the coming edge, then move to the next falling edge
    task automatic step(input string nm, input logic [8:0] e);
        name_q.push_back(nm);
        exp_q.push_back(e);
        @(negedge CLK_20Hz);
    endtask

    // Full attack with no movement and buttons possibly held throughout
    task automatic run_attack(input string nm, input logic [1:0] t,
                              input int w, input int a, input int r);
        for (int i = 0; i < w; i++) step({nm, "_windup"},  E(0, 0, 0, 0, t, 3'd3));
        for (int i = 0; i < a; i++) step({nm, "_active"},  E(0, 0, 0, 1, t, 3'd4));
        for (int i = 0; i < r; i++) step({nm, "_recover"}, E(0, 0, 0, 0, t, 3'd5));
    endtask

    // Monitor: compare outputs just after each active edge
    always @(posedge CLK_20Hz) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_v  = exp_q.pop_front();
            name_v = name_q.pop_front();
            checks++;
            if (dut_vec !== exp_v) begin
                failures++;
                $display("FAIL %s got=%b expected=%b (mL mR jmp act type[2] state[3])",
                         name_v, dut_vec, exp_v);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; btn_left = 0; btn_right = 0; btn_jump = 0; btn_punch = 1;
        btn_kick = 0; on_floor = 1; got_hit = 0;
        @(negedge CLK_20Hz);

        // Reset with punch held through deassertion
        step("reset0", E(0, 0, 0, 0, 0, 3'd0));
        step("reset1", E(0, 0, 0, 0, 0, 3'd0));
        reset = 1'b0;
        step("punch_held_after_reset", E(0, 0, 0, 0, 0, 3'd0));
        step("punch_held_after_reset2", E(0, 0, 0, 0, 0, 3'd0));
        btn_punch = 0;
        step("punch_released", E(0, 0, 0, 0, 0, 3'd0));

        // Walking
        btn_left = 1;
        for (int i = 0; i < 4; i++) step("walk_left", E(1, 0, 0, 0, 0, 3'd1));
        btn_right = 1;
        step("left_right_both", E(0, 0, 0, 0, 0, 3'd0));
        btn_left = 0;
        step("walk_right", E(0, 1, 0, 0, 0, 3'd1));
        btn_right = 0;
        step("stop", E(0, 0, 0, 0, 0, 3'd0));

        // Jump with floor still reported high for MIN_AIR ticks
        btn_jump = 1;
        step("jump_pulse", E(0, 0, 1, 0, 0, 3'd2));
        step("air_minair1", E(0, 0, 0, 0, 0, 3'd2));
        step("air_minair2", E(0, 0, 0, 0, 0, 3'd2));
        step("land", E(0, 0, 0, 0, 0, 3'd0));
        step("jump_held_no_repeat", E(0, 0, 0, 0, 0, 3'd0));
        btn_jump = 0;
        step("jump_released", E(0, 0, 0, 0, 0, 3'd0));

        // Jump, drift left in the air, punch ignored while airborne
        btn_jump = 1;
        step("jump2_pulse", E(0, 0, 1, 0, 0, 3'd2));
        btn_jump = 0; on_floor = 0; btn_left = 1;
        step("air_left1", E(1, 0, 0, 0, 0, 3'd2));
        step("air_left2", E(1, 0, 0, 0, 0, 3'd2));
        btn_punch = 1;
        step("air_punch_ignored", E(1, 0, 0, 0, 0, 3'd2));
        on_floor = 1;
        step("land_left", E(1, 0, 0, 0, 0, 3'd0));
        btn_punch = 0;
        step("walk_after_land", E(1, 0, 0, 0, 0, 3'd1));
        btn_left = 0;
        step("stop2", E(0, 0, 0, 0, 0, 3'd0));

        // Punch with right held: movement suppressed for 7 ticks
        btn_punch = 1; btn_right = 1;
        run_attack("punch", 2'd1, 2, 2, 3);
        step("punch_done_right", E(0, 1, 0, 0, 0, 3'd0));
        step("punch_held_walk", E(0, 1, 0, 0, 0, 3'd1));
        btn_punch = 0; btn_right = 0;
        step("idle3", E(0, 0, 0, 0, 0, 3'd0));

        // Punch and kick on the same tick: punch wins
        btn_punch = 1; btn_kick = 1;
        run_attack("punch_kick", 2'd1, 2, 2, 3);
        step("punch_kick_done", E(0, 0, 0, 0, 0, 3'd0));
        btn_punch = 0; btn_kick = 0;
        step("idle4", E(0, 0, 0, 0, 0, 3'd0));

        // Kick alone: 10-tick sequence
        btn_kick = 1;
        run_attack("kick", 2'd2, 3, 3, 4);
        step("kick_done", E(0, 0, 0, 0, 0, 3'd0));
        btn_kick = 0;
        step("idle5", E(0, 0, 0, 0, 0, 3'd0));

        // Hit during kick ACTIVE, re-hit extends stun, exit airborne
        btn_kick = 1;
        step("hk_windup1", E(0, 0, 0, 0, 2'd2, 3'd3));
        btn_kick = 0;
        step("hk_windup2", E(0, 0, 0, 0, 2'd2, 3'd3));
        step("hk_windup3", E(0, 0, 0, 0, 2'd2, 3'd3));
        step("hk_active", E(0, 0, 0, 1, 2'd2, 3'd4));
        got_hit = 1;
        step("hit_aborts_kick", E(0, 0, 0, 0, 0, 3'd6));
        got_hit = 0;
        step("stun_a1", E(0, 0, 0, 0, 0, 3'd6));
        step("stun_a2", E(0, 0, 0, 0, 0, 3'd6));
        got_hit = 1;
        step("rehit_reload", E(0, 0, 0, 0, 0, 3'd6));
        got_hit = 0;
        for (int i = 0; i < 5; i++) step("stun_b", E(0, 0, 0, 0, 0, 3'd6));
        on_floor = 0;
        step("stun_exit_air", E(0, 0, 0, 0, 0, 3'd2));
        on_floor = 1;
        step("air_land_after_stun", E(0, 0, 0, 0, 0, 3'd0));

        // Hit from IDLE, exit on floor
        got_hit = 1;
        step("hit_idle", E(0, 0, 0, 0, 0, 3'd6));
        got_hit = 0;
        for (int i = 0; i < 5; i++) step("stun_c", E(0, 0, 0, 0, 0, 3'd6));
        step("stun_exit_floor", E(0, 0, 0, 0, 0, 3'd0));

        // Reset mid-attack clears everything; held punch does not retrigger
        btn_punch = 1;
        step("ra_windup1", E(0, 0, 0, 0, 2'd1, 3'd3));
        step("ra_windup2", E(0, 0, 0, 0, 2'd1, 3'd3));
        step("ra_active", E(0, 0, 0, 1, 2'd1, 3'd4));
        reset = 1;
        step("reset_mid_attack", E(0, 0, 0, 0, 0, 3'd0));
        reset = 0;
        step("post_reset_held", E(0, 0, 0, 0, 0, 3'd0));
        btn_punch = 0;
        step("post_reset_release", E(0, 0, 0, 0, 0, 3'd0));
        btn_punch = 1;
        run_attack("punch_again", 2'd1, 2, 2, 3);
        btn_punch = 0;
        step("final_idle", E(0, 0, 0, 0, 0, 3'd0));

        // Every queued expectation must have been consumed
        @(posedge CLK_20Hz);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
